// File: rtl/game_timer_ctrl.sv
// ============================================================================
// Module      : game_timer_ctrl
// Description : Game flow controller: IDLE/READY countdown/RUN/PAUSE/OVER,
//               driving the seconds timer clear/enable and snake-move enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer_ctrl #(
  parameter logic [24:0] CNT_1S  = 25'd24_999_999,
  parameter logic [1:0]  CD_INIT = 2'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       game_over,
  output logic       clear_signal,
  output logic       start_signal,
  output logic       game_active,
  output logic [1:0] countdown,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [24:0] r_tick;
  logic [24:0] w_next_tick;
  logic [1:0]  r_countdown;
  logic [1:0]  w_next_countdown;
  logic        r_clear;
  logic        r_start;
  logic        r_active;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_tick      <= 25'd0;
      r_countdown <= 2'd0;
      r_clear     <= 1'b0;
      r_start     <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_tick      <= w_next_tick;
      r_countdown <= w_next_countdown;
      // Outputs are decoded from the next state so they line up with state.
      r_clear     <= (w_next_state == S_READY) && (r_state != S_READY);
      r_start     <= (w_next_state == S_RUN);
      r_active    <= (w_next_state == S_RUN);
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_tick      = 25'd0;
    w_next_countdown = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (btn_start) begin
          w_next_state     = S_READY;
          w_next_countdown = CD_INIT;
        end
      end
      S_READY: begin
        w_next_countdown = r_countdown;
        if (r_tick == CNT_1S) begin
          if (r_countdown <= 2'd1) begin
            w_next_state     = S_RUN;
            w_next_countdown = 2'd0;
          end else begin
            w_next_countdown = r_countdown - 2'd1;
          end
        end else begin
          w_next_tick = r_tick + 25'd1;
        end
      end
      S_RUN: begin
        if (game_over) begin
          w_next_state = S_OVER;
        end else if (btn_pause) begin
          w_next_state = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (btn_start) begin
          w_next_state     = S_READY;
          w_next_countdown = CD_INIT;
        end else if (btn_pause) begin
          w_next_state = S_RUN;
        end
      end
      S_OVER: begin
        if (btn_start) begin
          w_next_state     = S_READY;
          w_next_countdown = CD_INIT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign clear_signal = r_clear;
  assign start_signal = r_start;
  assign game_active  = r_active;
  assign countdown    = r_countdown;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
// ============================================================================
// Module      : tb_game_timer_ctrl
// Description : Vector-table bench for game_timer_ctrl (CNT_1S=4, CD_INIT=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_timer_ctrl;

  logic       sys_clk;
  logic       sys_rst;
  logic       btn_start;
  logic       btn_pause;
  logic       game_over;
  logic       clear_signal;
  logic       start_signal;
  logic       game_active;
  logic [1:0] countdown;
  logic [2:0] state;

  int checks;
  int errors;

  typedef struct {
    logic       rst;
    logic       start;
    logic       pause;
    logic       go;
    int         n;
    logic [2:0] e_state;
    logic       e_clr;
    logic       e_st;
    logic       e_act;
    logic [1:0] e_cd;
  } vec_t;

  vec_t vecs[$];

  game_timer_ctrl #(
    .CNT_1S (25'd4),
    .CD_INIT(2'd3)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .game_over   (game_over),
    .clear_signal(clear_signal),
    .start_signal(start_signal),
    .game_active (game_active),
    .countdown   (countdown),
    .state       (state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic add(input logic r, input logic s, input logic p, input logic g, input int n,
                     input logic [2:0] es, input logic ec, input logic est, input logic ea,
                     input logic [1:0] ecd);
    vec_t v;
    v.rst = r; v.start = s; v.pause = p; v.go = g; v.n = n;
    v.e_state = es; v.e_clr = ec; v.e_st = est; v.e_act = ea; v.e_cd = ecd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] es, input logic ec,
                       input logic est, input logic ea, input logic [1:0] ecd);
    checks++;
    if (state !== es || clear_signal !== ec || start_signal !== est ||
        game_active !== ea || countdown !== ecd) begin
      errors++;
      $display("FAIL %s: got state=%0d clr=%0b start=%0b act=%0b cd=%0d, want state=%0d clr=%0b start=%0b act=%0b cd=%0d",
               name, state, clear_signal, start_signal, game_active, countdown,
               es, ec, est, ea, ecd);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic g);
    @(negedge sys_clk);
    sys_rst = r; btn_start = s; btn_pause = p; game_over = g;
    @(posedge sys_clk);
    #1;
  endtask

  // Full 15-cycle countdown from READY entry (entry cycle already checked).
  task automatic add_countdown();
    add(0,0,0,0,4, 3'd1,0,0,0,2'd3);
    add(0,0,0,0,5, 3'd1,0,0,0,2'd2);
    add(0,0,0,0,5, 3'd1,0,0,0,2'd1);
    add(0,0,0,0,1, 3'd2,0,1,1,2'd0);
  endtask

  initial begin
    int clr_cnt;
    bit reached;
    checks = 0; errors = 0;
    sys_rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; game_over = 1'b0;

    //  rst st pa go  n  state clr st act cd
    add(1,0,0,0,2, 3'd0,0,0,0,2'd0);
    add(0,0,1,0,1, 3'd0,0,0,0,2'd0);
    add(0,0,0,1,1, 3'd0,0,0,0,2'd0);
    add(0,1,0,0,1, 3'd1,1,0,0,2'd3);
    add(0,1,0,0,1, 3'd1,0,0,0,2'd3);
    add(0,0,1,1,1, 3'd1,0,0,0,2'd3);
    add(0,0,0,0,2, 3'd1,0,0,0,2'd3);
    add(0,0,0,0,5, 3'd1,0,0,0,2'd2);
    add(0,0,0,0,5, 3'd1,0,0,0,2'd1);
    add(0,0,0,0,1, 3'd2,0,1,1,2'd0);
    add(0,1,0,0,1, 3'd2,0,1,1,2'd0);
    add(0,0,1,0,1, 3'd3,0,0,0,2'd0);
    add(0,0,0,1,1, 3'd3,0,0,0,2'd0);
    add(0,0,1,0,1, 3'd2,0,1,1,2'd0);
    add(0,0,1,1,1, 3'd4,0,0,0,2'd0);
    add(0,0,1,0,1, 3'd4,0,0,0,2'd0);
    add(0,1,0,0,1, 3'd1,1,0,0,2'd3);
    add(0,0,0,0,4, 3'd1,0,0,0,2'd3);
    add(0,0,0,0,5, 3'd1,0,0,0,2'd2);
    add(1,0,0,0,1, 3'd0,0,0,0,2'd0);
    add(0,0,0,0,1, 3'd0,0,0,0,2'd0);
    add(0,1,0,0,1, 3'd1,1,0,0,2'd3);
    add_countdown();
    add(0,0,1,0,1, 3'd3,0,0,0,2'd0);
    add(0,1,1,0,1, 3'd1,1,0,0,2'd3);
    add_countdown();
    add(0,0,0,1,20, 3'd4,0,0,0,2'd0);
    add(0,1,0,0,1, 3'd1,1,0,0,2'd3);
    add(0,0,0,0,1, 3'd1,0,0,0,2'd3);
    add(1,0,0,0,1, 3'd0,0,0,0,2'd0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        step(vecs[i].rst, vecs[i].start, vecs[i].pause, vecs[i].go);
        check($sformatf("vec%0d_cyc%0d", i, c), vecs[i].e_state, vecs[i].e_clr,
              vecs[i].e_st, vecs[i].e_act, vecs[i].e_cd);
      end
    end

    // Reset outranks a simultaneous start and yields no clear pulse.
    step(1,1,1,1);
    check("rst_priority", 3'd0,0,0,0,2'd0);

    // Start, then wait (bounded) for RUN while counting clear pulses.
    step(0,1,0,0);
    check("restart_entry", 3'd1,1,0,0,2'd3);
    clr_cnt = 0;
    reached = 1'b0;
    for (int c = 0; c < 30 && !reached; c++) begin
      step(0,0,0,0);
      if (clear_signal) clr_cnt++;
      if (state == 3'd2) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL run_timeout: got state=%0d, want state=2 within 30 cycles", state);
    end
    checks++;
    if (clr_cnt != 0) begin
      errors++;
      $display("FAIL clear_width: got %0d extra clear cycles, want 0", clr_cnt);
    end

    // Held game_over: single OVER entry, no clears while held.
    clr_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step(0,0,0,1);
      if (clear_signal) clr_cnt++;
    end
    check("held_over", 3'd4,0,0,0,2'd0);
    checks++;
    if (clr_cnt != 0) begin
      errors++;
      $display("FAIL held_over_clear: got %0d clear cycles, want 0", clr_cnt);
    end

    sys_rst = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; game_over = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
